// File: rtl/dispensador_troco.sv
// rtl/dispensador_troco.sv - payout FSM: price check, product release, coin-by-coin change, credit clear
module dispensador_troco #(
  parameter int MAX_CREDITO = 8,
  parameter int TIMEOUT_ACK = 255,
  parameter int W_TIMEOUT   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] valorAcumulado,
  input  logic [3:0] precoProduto,
  input  logic       comprar,
  input  logic       cancelar,
  input  logic       moedaAck,
  output logic       liberaProduto,
  output logic [1:0] moedaTroco,
  output logic       moedaValida,
  output logic       limpaCredito,
  output logic       ocupado,
  output logic       erro
);

  typedef enum logic [2:0] {
    OCIOSO,
    LIBERA,
    TROCO,
    ESPERA_ACK,
    FIM
  } estado_t;

  localparam logic [3:0]           CREDITO_MAX = 4'(MAX_CREDITO);
  localparam logic [W_TIMEOUT-1:0] CONT_LIMITE = W_TIMEOUT'(TIMEOUT_ACK - 1);

  estado_t              r_estado;
  logic [3:0]           r_troco;
  logic [W_TIMEOUT-1:0] r_cont;
  logic                 r_libera;
  logic [1:0]           r_moeda;
  logic                 r_valida;
  logic                 r_limpa;
  logic                 r_ocupado;
  logic                 r_erro;

  logic                 w_credito_valido;
  logic                 w_credito_suficiente;
  logic [1:0]           w_moeda_sel;
  logic [3:0]           w_valor_moeda;

  assign w_credito_valido     = (valorAcumulado <= CREDITO_MAX);
  assign w_credito_suficiente = (valorAcumulado >= precoProduto);

  // Greedy choice: largest coin that still fits in the remaining change
  always_comb begin
    w_moeda_sel = 2'b01;
    if (r_troco >= 4'd4)
      w_moeda_sel = 2'b11;
    else if (r_troco >= 4'd2)
      w_moeda_sel = 2'b10;
  end

  always_comb begin
    w_valor_moeda = 4'd1;
    case (r_moeda)
      2'b11:   w_valor_moeda = 4'd4;
      2'b10:   w_valor_moeda = 4'd2;
      default: w_valor_moeda = 4'd1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_estado  <= OCIOSO;
      r_troco   <= 4'd0;
      r_cont    <= '0;
      r_libera  <= 1'b0;
      r_moeda   <= 2'b00;
      r_valida  <= 1'b0;
      r_limpa   <= 1'b0;
      r_ocupado <= 1'b0;
      r_erro    <= 1'b0;
    end else begin
      r_libera <= 1'b0;
      r_limpa  <= 1'b0;
      r_erro   <= 1'b0;
      case (r_estado)
        OCIOSO: begin
          if (comprar) begin
            if (!w_credito_valido || !w_credito_suficiente) begin
              r_erro <= 1'b1;
            end else begin
              r_troco   <= valorAcumulado - precoProduto;
              r_estado  <= LIBERA;
              r_libera  <= 1'b1;
              r_ocupado <= 1'b1;
            end
          end else if (cancelar) begin
            r_ocupado <= 1'b1;
            if (w_credito_valido) begin
              r_troco  <= valorAcumulado;
              r_estado <= TROCO;
            end else begin
              r_troco  <= 4'd0;
              r_estado <= FIM;
              r_limpa  <= 1'b1;
            end
          end
        end

        LIBERA: begin
          r_estado <= TROCO;
        end

        TROCO: begin
          if (r_troco == 4'd0) begin
            r_estado <= FIM;
            r_limpa  <= 1'b1;
          end else begin
            r_moeda  <= w_moeda_sel;
            r_valida <= 1'b1;
            r_cont   <= '0;
            r_estado <= ESPERA_ACK;
          end
        end

        ESPERA_ACK: begin
          if (moedaAck) begin
            r_troco  <= r_troco - w_valor_moeda;
            r_valida <= 1'b0;
            r_moeda  <= 2'b00;
            r_estado <= TROCO;
          end else if (r_cont == CONT_LIMITE) begin
            // Ejector never answered: give up on the rest of the change
            r_erro   <= 1'b1;
            r_valida <= 1'b0;
            r_moeda  <= 2'b00;
            r_troco  <= 4'd0;
            r_estado <= FIM;
            r_limpa  <= 1'b1;
          end else begin
            r_cont <= r_cont + 1'b1;
          end
        end

        FIM: begin
          r_estado  <= OCIOSO;
          r_ocupado <= 1'b0;
        end

        default: begin
          r_estado  <= OCIOSO;
          r_ocupado <= 1'b0;
          r_valida  <= 1'b0;
          r_moeda   <= 2'b00;
        end
      endcase
    end
  end

  assign liberaProduto = r_libera;
  assign moedaTroco    = r_moeda;
  assign moedaValida   = r_valida;
  assign limpaCredito  = r_limpa;
  assign ocupado       = r_ocupado;
  assign erro          = r_erro;

endmodule
